// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin scheduler that shares one sign-magnitude
// fixed-point multiplier among NUM_REQ requesters.
// Two-stage pipeline: S1 holds the granted operands, S2 holds the finished
// product and drives the rsp_* outputs directly from registers.
// Optional build macro: MUL_SHARE_ARB_STATS_EN adds the ovf_count output,
// a saturating count of overflowed responses taken by the consumer.
module mul_share_arb #(
  parameter int WIDTH     = 12,
  parameter int FRAC_BITS = 6,
  parameter int NUM_REQ   = 4,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_prod,
  output logic                       rsp_overflow
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]                ovf_count
`endif
);

  localparam int MW = WIDTH - 1;

  logic [IDW-1:0]   r_last;
  logic             r_s1_valid;
  logic [IDW-1:0]   r_s1_id;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_prod;
  logic             r_rsp_ovf;

  logic             w_s2_adv;
  logic             w_accept;
  logic             w_xfer;
  logic             w_gnt_any;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW-1:0]   w_cand;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [2*MW-1:0]  w_shift;
  logic             w_ovf;
  logic [MW-1:0]    w_mag;
  logic             w_sign;

  // Pipeline advance: S2 frees when empty or consumed; S1 can take a new
  // entry whenever it is empty or moving into S2 this cycle.
  assign w_s2_adv = !r_rsp_valid || rsp_ready;
  assign w_accept = !r_s1_valid || w_s2_adv;
  // rst_n gates the grant so nothing is offered while reset is asserted.
  assign w_xfer   = w_gnt_any && w_accept && rst_n;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_last) + 1 + k) % NUM_REQ);
      if (!w_gnt_any && req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // One-hot ready for the granted requester, only when S1 can accept.
  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt_idx] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_idx == IDW'(k)) begin
        w_sel_a = req_a[k*WIDTH +: WIDTH];
        w_sel_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Sign-magnitude multiply with realignment, saturation and zero cleanup.
  always_comb begin
    w_shift = ({{MW{1'b0}}, r_s1_a[MW-1:0]} * {{MW{1'b0}}, r_s1_b[MW-1:0]}) >> FRAC_BITS;
    w_ovf   = |w_shift[2*MW-1:MW];
    w_mag   = w_ovf ? {MW{1'b1}} : w_shift[MW-1:0];
    // A zero magnitude is always reported positive, whatever the input signs.
    w_sign  = (r_s1_a[MW] ^ r_s1_b[MW]) && (w_mag != '0);
  end

  // Round-robin pointer moves only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= IDW'(NUM_REQ - 1);
    else if (w_xfer) r_last <= w_gnt_idx;
  end

  // S1 operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_accept) begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_id <= w_gnt_idx;
        r_s1_a  <= w_sel_a;
        r_s1_b  <= w_sel_b;
      end
    end
  end

  // S2 result register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_prod  <= '0;
      r_rsp_ovf   <= 1'b0;
    end else if (w_s2_adv) begin
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_id   <= r_s1_id;
        r_rsp_prod <= {w_sign, w_mag};
        r_rsp_ovf  <= w_ovf;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_prod     = r_rsp_prod;
  assign rsp_overflow = r_rsp_ovf;

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] r_ovf_count;

  // Saturating count of overflowed responses, taken on the rsp transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf_count <= '0;
    else if (r_rsp_valid && rsp_ready && r_rsp_ovf && (r_ovf_count != 16'hFFFF))
      r_ovf_count <= r_ovf_count + 16'd1;
  end

  assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb (default parameters).
module tb_mul_share_arb;

  localparam int W = 12;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_prod;
  logic            rsp_overflow;
`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0]     ovf_count;
`endif

  mul_share_arb #(.WIDTH(W), .FRAC_BITS(6), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_overflow(rsp_overflow)
`ifdef MUL_SHARE_ARB_STATS_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] prod;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] prod;
    logic        ovf;
  } exp_t;

  vec_t tbl[11];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int xfer_cyc = 0;
  int xfer_id = 0;
  bit xfer_hit = 0;
  int got_cnt = 0;
  int got_cyc = 0;
  logic [1:0]  got_id;
  logic [11:0] got_prod;
  logic        got_ovf;
  int exp_ovf = 0;

  // Reference arithmetic: 11-bit magnitudes, 6 fractional bits.
  function automatic logic [12:0] model(logic [11:0] a, logic [11:0] b);
    int unsigned p;
    logic [10:0] mag;
    logic ovf;
    logic s;
    p   = (int'(a[10:0]) * int'(b[10:0])) / 64;
    ovf = (p > 2047);
    mag = ovf ? 11'h7FF : p[10:0];
    s   = (a[11] != b[11]) && (mag != 11'd0);
    return {ovf, s, mag};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: pop on rsp transfer, push on request transfer.
  task automatic monitor();
    exp_t e;
    logic [12:0] m;
    xfer_hit = 0;
    if (!rst_n) return;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_unexpected actual id=%0d prod=%0h required none", rsp_id, rsp_prod);
      end else begin
        e = sb.pop_front();
        check("sb_id", 32'(rsp_id), 32'(e.id));
        check("sb_prod", 32'(rsp_prod), 32'(e.prod));
        check("sb_ovf", 32'(rsp_overflow), 32'(e.ovf));
        if (e.ovf) exp_ovf++;
      end
      got_cnt++; got_cyc = cyc;
      got_id = rsp_id; got_prod = rsp_prod; got_ovf = rsp_overflow;
    end
    check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        m = model(req_a[i*W +: W], req_b[i*W +: W]);
        e.id = 2'(i); e.prod = m[11:0]; e.ovf = m[12];
        sb.push_back(e);
        xfer_hit = 1; xfer_id = i; xfer_cyc = cyc; xfer_cnt++;
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    monitor();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    half();
    rise();
  endtask

  task automatic rand_ops(int i);
    req_a[i*W +: W] = 12'($urandom);
    req_b[i*W +: W] = 12'($urandom);
  endtask

  initial begin
    int prev;
    int c0;
    int x0;
    logic [15:0] snap;

    tbl[0]  = '{0, 12'h060, 12'h080, 12'h0C0, 1'b0};
    tbl[1]  = '{1, 12'h860, 12'h080, 12'h8C0, 1'b0};
    tbl[2]  = '{2, 12'h800, 12'h060, 12'h000, 1'b0};
    tbl[3]  = '{3, 12'h001, 12'h001, 12'h000, 1'b0};
    tbl[4]  = '{0, 12'h7FF, 12'hFFF, 12'hFFF, 1'b1};
    tbl[5]  = '{1, 12'h040, 12'h8A5, 12'h8A5, 1'b0};
    tbl[6]  = '{2, 12'h87F, 12'h87F, 12'h0FC, 1'b0};
    tbl[7]  = '{3, 12'h7FF, 12'h040, 12'h7FF, 1'b0};
    tbl[8]  = '{0, 12'h400, 12'h081, 12'h7FF, 1'b1};
    tbl[9]  = '{1, 12'h800, 12'h800, 12'h000, 1'b0};
    tbl[10] = '{2, 12'h003, 12'h815, 12'h000, 1'b0};

    // Reset state, with requests already pending.
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    check("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
`ifdef MUL_SHARE_ARB_STATS_EN
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    rise();

    // Table-driven single transactions with latency check.
    for (int t = 0; t < 11; t++) begin
      req_a[tbl[t].id*W +: W] = tbl[t].a;
      req_b[tbl[t].id*W +: W] = tbl[t].b;
      req_valid = 4'(1 << tbl[t].id);
      x0 = xfer_cnt;
      for (int w = 0; w < 10 && xfer_cnt == x0; w++) tick();
      req_valid = '0;
      if (xfer_cnt == x0) begin
        n_cmp++; n_bad++;
        $display("FAIL vec%0d_grant actual=none required=transfer", t);
      end else begin
        c0 = got_cnt;
        for (int w = 0; w < 10 && got_cnt == c0; w++) tick();
        if (got_cnt == c0) begin
          n_cmp++; n_bad++;
          $display("FAIL vec%0d_rsp actual=none required=response", t);
        end else begin
          check($sformatf("vec%0d_latency", t), 32'(got_cyc - xfer_cyc), 32'd2);
          check($sformatf("vec%0d_id", t), 32'(got_id), 32'(tbl[t].id));
          check($sformatf("vec%0d_prod", t), 32'(got_prod), 32'(tbl[t].prod));
          check($sformatf("vec%0d_ovf", t), 32'(got_ovf), 32'(tbl[t].ovf));
        end
      end
    end

    // Fairness and throughput: all requesters valid, consumer always ready.
    for (int i = 0; i < N; i++) rand_ops(i);
    prev = tbl[10].id;
    req_valid = '1;
    c0 = got_cnt;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (!xfer_hit) begin
        n_cmp++; n_bad++;
        $display("FAIL fair_gap actual=no_grant required=grant (k=%0d)", k);
      end else begin
        check("fair_order", 32'(xfer_id), 32'((prev + 1) % N));
        prev = xfer_id;
        rand_ops(xfer_id);
      end
    end
    check("fair_rsp_count", 32'(got_cnt - c0), 32'd10);

    // Backpressure: empty S1 for one cycle, then stall the consumer.
    req_valid = '0;
    tick();
    req_valid = '1;
    rsp_ready = 1'b0;
    x0 = xfer_cnt;
    snap = '0;
    for (int s = 0; s < 3; s++) begin
      half();
      if (s == 0) begin
        check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        snap = {1'b0, rsp_valid, rsp_id, rsp_prod, rsp_overflow};
      end else begin
        check("stall_hold", 32'({1'b0, rsp_valid, rsp_id, rsp_prod, rsp_overflow}), 32'(snap));
        check("stall_ready_zero", 32'(req_ready), 32'd0);
      end
      rise();
      if (xfer_hit) rand_ops(xfer_id);
    end
    check("stall_accepts", 32'(xfer_cnt - x0), 32'd1);
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
    for (int w = 0; w < 3; w++) tick();

    // Reset with S1 and S2 both full.
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int w = 0; w < 3; w++) tick();
    half();
    check("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("prerst_ready", 32'(req_ready), 32'd0);
    rise();
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_id", 32'(rsp_id), 32'd0);
    check("midrst_rsp_prod", 32'(rsp_prod), 32'd0);
    check("midrst_rsp_ovf", 32'(rsp_overflow), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    exp_ovf = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    monitor();
    check("postrst_first_grant", 32'(xfer_hit ? xfer_id : -1), 32'd0);
    rise();
    req_valid = '0;
    for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
    check("final_drain_empty", 32'(sb.size()), 32'd0);
    for (int w = 0; w < 3; w++) tick();
`ifdef MUL_SHARE_ARB_STATS_EN
    check("ovf_count", 32'(ovf_count), 32'(exp_ovf));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin scheduler that shares one sign-magnitude fixed-point multiplier among `NUM_REQ` requesters, such as LSTM gate datapaths.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle and runs the product through a two-stage pipeline.
- It returns the result tagged with the requester index.
- Arithmetic is in-block: sign-magnitude multiply, `FRAC_BITS` realignment, saturation on overflow, and zero normalisation.

## Interface
- `WIDTH`, 12, total operand/result bits (bit `WIDTH-1` = sign, rest = magnitude)
- `FRAC_BITS`, 6, fractional bits of the magnitude
- `NUM_REQ`, 4, number of requesters (2..8); `IDW = $clog2(NUM_REQ)`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  per-requester accept (one-hot or zero)
- `req_a`  in  NUM_REQ*WIDTH  operand A; requester i at `[i*WIDTH +: WIDTH]`
- `req_b`  in  NUM_REQ*WIDTH  operand B; same packing as `req_a`
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  IDW  index of the requester that issued the operands
- `rsp_prod`  out  WIDTH  sign-magnitude product
- `rsp_overflow`  out  1  magnitude saturated

## Operation
- **Transfer rule:** a transfer happens on requester i when `req_valid[i] && req_ready[i]` at a rising edge. The requester holds `req_a`/`req_b` stable until its transfer.
- **Pipeline:**
  - S1 register: `{id, a, b}`.
  - S2 output register: `{id, prod, overflow}`, driving the `rsp_*` outputs.
- **Advance conditions:**
  - `s2_adv = !rsp_valid || rsp_ready`
  - `s1_adv = s1_valid && s2_adv`
  - `accept = !s1_valid || s2_adv`
- **Arbiter:**
  - Combinational round-robin over `req_valid`, with priority starting at `(last+1) mod NUM_REQ`.
  - `req_ready` is the one-hot grant, gated by `accept`.
  - `last` updates to the granted index only on a transfer.
  - A requester with valid asserted is granted within `NUM_REQ` accepting cycles (no starvation).
- **Arithmetic (S1→S2):**
  - `ma`/`mb` = low `WIDTH-1` bits.
  - `p = (ma*mb) >> FRAC_BITS`, computed at `2*(WIDTH-1)` bits and truncated toward zero.
  - `overflow = p > 2^(WIDTH-1)-1`.
  - `mag = overflow ? all-ones : p[WIDTH-2:0]`.
  - `sign = sa ^ sb`, forced to 0 when `mag == 0`. Negative zero never appears on output; negative-zero inputs behave as zero.
- **Reset:**
  - Values: `s1_valid=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_prod=0`, `rsp_overflow=0`, `last=NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready` is combinationally 0 while `rst_n` is low.
  - Reset mid-operation drops in-flight entries with no response emitted.

## Timing
- **Latency:** a transfer at edge N gives `rsp_valid=1` after edge N+1, i.e. the result is visible in the cycle following N+1 and is registered.
- **Throughput:** one result per cycle when `rsp_ready` is held high.
- **Hold under stall:** while `rsp_valid && !rsp_ready`, all `rsp_*` outputs hold stable.
- **Stall capacity:** S1 may hold one more entry during a stall. `req_ready` is all-zero once S1 and S2 are both full and the consumer is stalled.
- **Simultaneous events:** with S2 full, the rsp transfer, S1→S2 move and a new request accept all occur in the same cycle (no bubble).
- **Input-to-output path:** `req_ready` depends combinationally on `req_valid`, `rsp_ready` and state. It does not depend on `req_a`/`req_b`.
- **Registered outputs:** all `rsp_*` outputs are register outputs.

## Configuration
- **`MUL_SHARE_ARB_STATS_EN`:**
  - When defined, adds an output port `ovf_count` (16 bits): a count of responses with `rsp_overflow=1`, counted on the rsp transfer.
  - The counter saturates at 0xFFFF and resets to 0.
- **Without the macro:** the port and counter are absent; behaviour is otherwise identical.

## Test plan
- **Basic multiply:** defaults; req0 sends a=0x060 (1.5), b=0x080 (2.0); `rsp_ready=1` → after 2 edges `rsp_valid=1`, `rsp_id=0`, `rsp_prod=0x0C0`, `rsp_overflow=0`.
- **Sign and zero:**
  - a=0x860, b=0x080 → 0x8C0.
  - a=0x800, b=0x060 → 0x000.
  - a=0x001, b=0x001 → p=0 → 0x000 (sign cleared).
- **Saturation:** a=0x7FF, b=0xFFF → `rsp_prod=0xFFF`, `rsp_overflow=1`; with `MUL_SHARE_ARB_STATS_EN`, `ovf_count` goes 0→1.
- **Fairness:** all four requesters hold valid continuously, `rsp_ready=1` → grant order 0,1,2,3,0,1…; `rsp_id` follows the same order two cycles later, with no gaps.
- **Backpressure:** pipeline streaming, then `rsp_ready=0` for 3 cycles →
  - `rsp_*` stable;
  - exactly one further accept, then `req_ready=0`;
  - on release, results drain in order and none are lost or duplicated.
- **Reset mid-operation:** assert `rst_n=0` with S1 and S2 full → outputs go to reset values immediately, no stale `rsp_valid` after release, and the first grant goes to req0.
